// File: rtl/riscv_definitions.sv
// Shared bus types and the memory-responder state encoding.
package riscv_definitions;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_LANES  = DATA_WIDTH / 8;

    typedef logic [DATA_WIDTH-1:0] dataBus_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } memRespState_t;

endpackage

// File: rtl/byte_lane_ram.sv
// Word storage built from byte-wide lanes with per-lane write enable and a registered read port.
module byte_lane_ram
    import riscv_definitions::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AW-1:0]        addr_i,
    input  logic [NUM_LANES-1:0] we_i,
    input  dataBus_t             wdata_i,
    input  logic                 re_i,
    input  logic [NUM_LANES-1:0] rmask_i,
    output dataBus_t             rdata_o
);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [7:0] mem_q [DEPTH_WORDS];
        logic [7:0] rd_q;

        // Storage itself is deliberately reset-less; only the read register clears.
        always_ff @(posedge clk_i) begin
            if (we_i[l]) begin
                mem_q[addr_i] <= wdata_i[8*l +: 8];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_q <= '0;
            end else if (re_i) begin
                rd_q <= rmask_i[l] ? mem_q[addr_i] : 8'h00;
            end
        end

        assign rdata_o[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: accepts one core request, stalls WAIT_CYCLES, then completes.
module data_mem_responder
    import riscv_definitions::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  dataBus_t             i_data_addr,
    input  dataBus_t             i_data_wr,
    input  logic [NUM_LANES-1:0] i_data_rd_en_ctrl,
    input  logic                 i_data_rd_en_ma,
    input  logic                 i_data_wr_en_ma,
    output dataBus_t             o_data_rd,
    output logic                 o_data_ready,
    output logic                 o_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    memRespState_t        state_q;
    logic [3:0]           cnt_q;
    dataBus_t             addr_q;
    dataBus_t             wdata_q;
    logic [NUM_LANES-1:0] mask_q;
    logic                 rd_q;
    logic                 wr_q;
    logic                 err_q;

    logic                 req;
    logic                 idle;
    logic                 commit;
    dataBus_t             eff_addr;
    dataBus_t             eff_wdata;
    logic [NUM_LANES-1:0] eff_mask;
    logic                 eff_rd;
    logic                 eff_wr;
    logic                 oor;
    logic [NUM_LANES-1:0] ram_we;
    logic                 ram_re;
    logic [NUM_LANES-1:0] ram_rmask;
    logic                 unused_addr_lsb;

    // With one-cycle latency the commit edge is the accept edge, so use the live inputs in IDLE.
    always_comb begin
        req       = i_data_rd_en_ma | i_data_wr_en_ma;
        idle      = (state_q == IDLE);
        eff_addr  = idle ? i_data_addr       : addr_q;
        eff_wdata = idle ? i_data_wr         : wdata_q;
        eff_mask  = idle ? i_data_rd_en_ctrl : mask_q;
        eff_rd    = idle ? i_data_rd_en_ma   : rd_q;
        eff_wr    = idle ? i_data_wr_en_ma   : wr_q;
        oor       = |eff_addr[DATA_WIDTH-1:AW+2];
        commit    = idle ? (req && (WAIT_CYCLES == 1))
                         : ((state_q == WAIT) && (cnt_q == 4'd1));
        ram_we    = (commit && eff_wr && !oor) ? eff_mask : '0;
        ram_re    = commit && !eff_wr;
        ram_rmask = oor ? '0 : eff_mask;
        o_data_ready = idle ? !req : (state_q == RESP);
    end

    assign unused_addr_lsb = ^eff_addr[1:0];
    assign o_err           = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= commit && (oor || (eff_rd && eff_wr));
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= i_data_addr;
                        wdata_q <= i_data_wr;
                        mask_q  <= i_data_rd_en_ctrl;
                        rd_q    <= i_data_rd_en_ma;
                        wr_q    <= i_data_wr_en_ma;
                        cnt_q   <= 4'(WAIT_CYCLES - 1);
                        state_q <= (WAIT_CYCLES == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    byte_lane_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .addr_i (eff_addr[AW+1:2]),
        .we_i   (ram_we),
        .wdata_i(eff_wdata),
        .re_i   (ram_re),
        .rmask_i(ram_rmask),
        .rdata_o(o_data_rd)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a 2-cycle/1024-word instance and a 1-cycle/16-word one.
module tb_data_mem_responder;
    import riscv_definitions::*;

    localparam int unsigned WC    = 2;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dataBus_t   a_addr, a_wdata, a_rdata;
    logic [3:0] a_mask;
    logic       a_rd, a_wr, a_ready, a_err;

    dataBus_t   b_addr, b_wdata, b_rdata;
    logic [3:0] b_mask;
    logic       b_rd, b_wr, b_ready, b_err;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u_dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_data_addr      (a_addr),
        .i_data_wr        (a_wdata),
        .i_data_rd_en_ctrl(a_mask),
        .i_data_rd_en_ma  (a_rd),
        .i_data_wr_en_ma  (a_wr),
        .o_data_rd        (a_rdata),
        .o_data_ready     (a_ready),
        .o_err            (a_err)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(1)) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_data_addr      (b_addr),
        .i_data_wr        (b_wdata),
        .i_data_rd_en_ctrl(b_mask),
        .i_data_rd_en_ma  (b_rd),
        .i_data_wr_en_ma  (b_wr),
        .o_data_rd        (b_rdata),
        .o_data_ready     (b_ready),
        .o_err            (b_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd = '0;

    task automatic push_expect(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] mask, input logic rd, input logic wr);
        exp_t        e;
        logic        oor;
        int          idx;
        logic [31:0] lanes;
        oor   = (addr >= 32'(4 * DEPTH));
        idx   = int'(addr[11:2]);
        lanes = '0;
        for (int l = 0; l < 4; l++) begin
            if (mask[l]) lanes[8*l +: 8] = 8'hFF;
        end
        if (wr) begin
            if (!oor) model_mem[idx] = (model_mem[idx] & ~lanes) | (wdata & lanes);
        end else begin
            model_rd = oor ? 32'h0 : (model_mem[idx] & lanes);
        end
        e.rd  = model_rd;
        e.err = oor | (rd & wr);
        e.lat = WC;
        exp_q.push_back(e);
    endtask

    task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic rd, input logic wr);
        exp_t e;
        int   lat;
        @(negedge clk);
        a_addr  = addr;
        a_wdata = wdata;
        a_mask  = mask;
        a_rd    = rd;
        a_wr    = wr;
        push_expect(addr, wdata, mask, rd, wr);
        #1;
        lat = 0;
        while (a_ready !== 1'b1 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        e = exp_q.pop_front();
        check_val({tag, "/latency"}, 32'(lat), 32'(e.lat));
        check_val({tag, "/rdata"}, a_rdata, e.rd);
        check_val({tag, "/err"}, {31'b0, a_err}, {31'b0, e.err});
        a_rd = 1'b0;
        a_wr = 1'b0;
        @(negedge clk);
        #1;
        check_val({tag, "/idle_ready"}, {31'b0, a_ready}, 32'd1);
        check_val({tag, "/err_clear"}, {31'b0, a_err}, 32'd0);
        check_val({tag, "/rdata_hold"}, a_rdata, e.rd);
    endtask

    initial begin
        a_addr = '0; a_wdata = '0; a_mask = '0; a_rd = 1'b0; a_wr = 1'b0;
        b_addr = '0; b_wdata = '0; b_mask = '0; b_rd = 1'b0; b_wr = 1'b0;

        #12;
        check_val("reset/rdata", a_rdata, 32'h0);
        check_val("reset/err", {31'b0, a_err}, 32'd0);
        check_val("reset/ready_noreq", {31'b0, a_ready}, 32'd1);
        a_rd = 1'b1;
        #1;
        check_val("reset/ready_req", {31'b0, a_ready}, 32'd0);
        a_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        txn("wr0", 32'h0000_0000, 32'h1122_3344, 4'hF, 1'b0, 1'b1);
        txn("wr10", 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
        txn("rd10", 32'h0000_0010, 32'h0, 4'hF, 1'b1, 1'b0);
        txn("wr10_lane1", 32'h0000_0010, 32'h0000_AB00, 4'b0010, 1'b0, 1'b1);
        txn("rd10_full", 32'h0000_0010, 32'h0, 4'hF, 1'b1, 1'b0);
        txn("rd10_hi", 32'h0000_0010, 32'h0, 4'b1100, 1'b1, 1'b0);
        txn("wr_oor", 32'h0000_1000, 32'h5555_5555, 4'hF, 1'b0, 1'b1);
        txn("rd0_after_oor", 32'h0000_0000, 32'h0, 4'hF, 1'b1, 1'b0);
        txn("rd_oor", 32'h0000_1004, 32'h0, 4'hF, 1'b1, 1'b0);
        txn("rd_mask0", 32'h0000_0010, 32'h0, 4'h0, 1'b1, 1'b0);
        txn("wr_mask0", 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1);
        txn("rd10_after_mask0", 32'h0000_0010, 32'h0, 4'hF, 1'b1, 1'b0);
        txn("rdwr_both", 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b1);
        txn("rd30", 32'h0000_0030, 32'h0, 4'hF, 1'b1, 1'b0);
        txn("rd_unaligned", 32'h0000_0013, 32'h0, 4'hF, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ad;
            ad = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            txn("rand_wr", ad, $urandom, 4'hF, 1'b0, 1'b1);
            txn("rand_rd", ad, 32'h0, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
        end

        // Abort a write to 0x20 while it is waiting; the old word must survive.
        txn("wr20", 32'h0000_0020, 32'h1234_5678, 4'hF, 1'b0, 1'b1);
        txn("rd10_pre_abort", 32'h0000_0010, 32'h0, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        a_addr = 32'h0000_0020; a_wdata = 32'hFFFF_FFFF; a_mask = 4'hF; a_wr = 1'b1;
        #1;
        check_val("abort/ready_c0", {31'b0, a_ready}, 32'd0);
        @(negedge clk);
        #1;
        check_val("abort/ready_wait", {31'b0, a_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("abort/rdata", a_rdata, 32'h0);
        check_val("abort/err", {31'b0, a_err}, 32'd0);
        a_wr = 1'b0;
        #1;
        check_val("abort/ready_idle", {31'b0, a_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_rd = '0;
        txn("rd20_after_abort", 32'h0000_0020, 32'h0, 4'hF, 1'b1, 1'b0);

        // One-cycle instance: request held three cycles gives two back-to-back transactions.
        @(negedge clk);
        b_addr = 32'h0; b_wdata = 32'hA5A5_A5A5; b_mask = 4'hF; b_wr = 1'b1;
        #1;
        check_val("b_held/ready0", {31'b0, b_ready}, 32'd0);
        @(negedge clk);
        #1;
        check_val("b_held/ready1", {31'b0, b_ready}, 32'd1);
        @(negedge clk);
        #1;
        check_val("b_held/ready2", {31'b0, b_ready}, 32'd0);
        b_wr = 1'b0;
        @(negedge clk);
        #1;
        check_val("b_held/ready3", {31'b0, b_ready}, 32'd1);
        @(negedge clk);
        #1;
        check_val("b_held/idle", {31'b0, b_ready}, 32'd1);
        b_rd = 1'b1;
        #1;
        check_val("b_rd/ready0", {31'b0, b_ready}, 32'd0);
        @(negedge clk);
        #1;
        check_val("b_rd/ready1", {31'b0, b_ready}, 32'd1);
        check_val("b_rd/rdata", b_rdata, 32'hA5A5_A5A5);
        check_val("b_rd/err", {31'b0, b_err}, 32'd0);
        b_addr = 32'h40;
        b_rd = 1'b0;
        @(negedge clk);
        b_rd = 1'b1;
        @(negedge clk);
        #1;
        check_val("b_oor/rdata", b_rdata, 32'h0);
        check_val("b_oor/err", {31'b0, b_err}, 32'd1);
        b_rd = 1'b0;
        @(negedge clk);
        #1;
        check_val("b_oor/err_clear", {31'b0, b_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, request-to-ready latency in cycles (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_data_addr  input  32 (dataBus_t)  byte address from core.
REQ-006 SHALL have port i_data_wr  input  32 (dataBus_t)  write data from core.
REQ-007 SHALL have port i_data_rd_en_ctrl  input  4  byte-lane mask, bit n = byte n.
REQ-008 SHALL have port i_data_rd_en_ma  input  1  read request.
REQ-009 SHALL have port i_data_wr_en_ma  input  1  write request.
REQ-010 SHALL have port o_data_rd  output  32 (dataBus_t)  registered read data.
REQ-011 SHALL have port o_data_ready  output  1  core may advance; low = stall.
REQ-012 SHALL have port o_err  output  1  one-cycle error flag coincident with completion.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: o_data_ready = NOT (rd_en OR wr_en); combinational from request inputs only.
REQ-015 IDLE with request: latch addr, wdata, mask, op; cnt <= WAIT_CYCLES-1; go RESP if WAIT_CYCLES=1, else WAIT.
REQ-016 WAIT: o_data_ready=0; cnt decrements each cycle; cnt=1 -> next state RESP.
REQ-017 RESP: o_data_ready=1 for exactly one cycle; next state IDLE unconditionally.
REQ-018 Request still asserted in RESP SHALL NOT be re-accepted; request asserted in following IDLE cycle is a new transaction.
REQ-019 Latency: request first seen in IDLE at cycle 0 -> o_data_ready high at cycle WAIT_CYCLES, low cycles 0..WAIT_CYCLES-1.
REQ-020 Index = latched addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
REQ-021 Write: committed on edge entering RESP; only lanes with mask=1 updated; other bytes unchanged.
REQ-022 Read: o_data_rd loaded on edge entering RESP; enabled lanes carry word bytes, disabled lanes read 0.
REQ-023 o_data_rd SHALL hold value until next read completion; writes leave it unchanged.
REQ-024 Out of range (addr >= 4*DEPTH_WORDS): write suppressed, read returns 0, o_err=1 in RESP.
REQ-025 rd_en and wr_en both high: treated as write, o_err=1 in RESP.
REQ-026 Mask 4'b0000 with request: completes normally, no bytes written, read returns 0, o_err=0.
REQ-027 Read-after-write to same word in consecutive transactions SHALL return new data.

Reset
REQ-028 rst_n low SHALL force state IDLE, cnt=0, o_data_rd=0, o_err=0, latched request cleared, asynchronously.
REQ-029 Reset mid-transaction SHALL abort it; pending write not committed.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 o_data_ready during reset SHALL follow REQ-014 (IDLE).

Structure
REQ-032 dataBus_t, DATA_WIDTH and new enum memRespState_t (IDLE, WAIT, RESP) SHALL live in riscv_definitions.
REQ-033 Storage SHALL be sub-module byte_lane_ram (4 byte-wide lanes, per-lane write enable, synchronous read).
REQ-034 FSM, counter and error logic SHALL stay in data_mem_responder.

Verification
REQ-035 WAIT_CYCLES=2: write 0xDEADBEEF mask 4'hF to 0x10 -> ready low 2 cycles, high cycle 2; read 0x10 -> o_data_rd=0xDEADBEEF.
REQ-036 Mask 4'b0010 write 0x0000AB00 to 0x10 then full read -> 0xDEADABEF.
REQ-037 Read 0x10 mask 4'b1100 -> o_data_rd=0xDEAD0000.
REQ-038 DEPTH_WORDS=1024, write to 0x1000 -> o_err=1 in RESP only; read of 0x0000 unchanged.
REQ-039 rst_n low during WAIT of write to 0x20 -> state IDLE, o_data_rd=0; later read 0x20 returns prior contents.
REQ-040 WAIT_CYCLES=1, request held 3 cycles -> two transactions, ready pattern 0,1,0,1.
